// File: rtl/output_writeback_pkg.sv
// ---------------------------------------------------------------------------
// output_writeback_pkg
// Shared constants and types for the result write-back block.
//   LINE_W          : width of one result line (512 bits)
//   DEF_ADDR_W      : default host line-address width
//   DEF_FIFO_DEPTH  : default buffer depth (lines)
//   DEF_MAX_BURST   : default number of lines the core may send per grant
//   CNT_W           : width of the written-line counter
//   wb_state_e      : grant FSM states
// ---------------------------------------------------------------------------
package output_writeback_pkg;

  localparam int LINE_W         = 512;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_MAX_BURST  = 8;
  localparam int CNT_W          = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/output_writeback_if.sv
// ---------------------------------------------------------------------------
// Bus interfaces of the result write-back block.
//   ow_core_if : result stream from the SMEM core.
//                master = core, slave = write-back block.
//                output_request/output_valid/output_finish/output_data go
//                core -> write-back, output_permit goes back to the core.
//   ow_host_if : host write port.
//                master = write-back block, slave = host.
//                wr_valid/wr_addr/wr_data go to the host, wr_ready returns.
// ---------------------------------------------------------------------------
interface ow_core_if
  import output_writeback_pkg::*;
  ;
  logic              output_request;
  logic              output_permit;
  logic [LINE_W-1:0] output_data;
  logic              output_valid;
  logic              output_finish;

  modport master (
    output output_request, output_data, output_valid, output_finish,
    input  output_permit
  );

  modport slave (
    input  output_request, output_data, output_valid, output_finish,
    output output_permit
  );
endinterface

interface ow_host_if
  import output_writeback_pkg::*;
  #(parameter int ADDR_W = DEF_ADDR_W);
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [LINE_W-1:0] wr_data;
  logic              wr_ready;

  modport master (
    output wr_valid, wr_addr, wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    output wr_ready
  );
endinterface

// File: rtl/output_writeback_wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Synchronous first-word-fall-through FIFO for result lines.
//   clk, rst_n   : clock, asynchronous active-low reset (pointers/count only)
//   push_i       : write push_data_i this cycle (caller ensures !full || pop)
//   push_data_i  : line to store
//   pop_i        : discard head this cycle (caller ensures !empty)
//   head_o       : current head line, valid while !empty_o
//   full_o       : all entries occupied
//   empty_o      : no entries occupied
//   count_o      : registered occupancy
// ---------------------------------------------------------------------------
module wb_fifo
  import output_writeback_pkg::*;
  #(
    parameter int WIDTH = LINE_W,
    parameter int DEPTH = DEF_FIFO_DEPTH
  ) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
  );

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset: a reset simply empties the FIFO via the pointers.
  always_ff @(posedge clk) begin
    if (push_i) mem[wr_ptr_q] <= push_data_i;
  end

  // Head is read straight from the array so a line pushed in cycle N is
  // visible to the host in cycle N+1.
  assign head_o  = mem[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/output_writeback.sv
// ---------------------------------------------------------------------------
// output_writeback
// Accepts bursts of result lines from the SMEM core, buffers them and writes
// them to the host at sequential line addresses, reporting batch completion.
//   Clk_32UI      : clock
//   reset_n       : asynchronous active-low reset
//   start         : begin a new batch (latch wr_base_addr, clear count/errors)
//   wr_base_addr  : base line address of the result region
//   core          : result stream (request/permit/data/valid/finish)
//   host          : host write port (valid/addr/data/ready)
//   lines_written : lines accepted by the host since start
//   batch_done    : one-cycle pulse once a finished grant is fully written
//   overflow_err  : sticky, a beat was dropped
//   start_err     : sticky, a start was ignored because the block was busy
// ---------------------------------------------------------------------------
module output_writeback
  import output_writeback_pkg::*;
  #(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int ADDR_W     = DEF_ADDR_W
  ) (
    input  logic              Clk_32UI,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] wr_base_addr,
    ow_core_if.slave          core,
    ow_host_if.master         host,
    output logic [CNT_W-1:0]  lines_written,
    output logic              batch_done,
    output logic              overflow_err,
    output logic              start_err
  );

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wb_state_e         state_q;
  logic              permit_q;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  line_cnt_q, line_cnt_d;
  logic              pending_q, pending_d;
  logic              overflow_q, overflow_d;
  logic              start_err_q, start_err_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [LINE_W-1:0] fifo_head;
  logic [CW-1:0]     free_entries;

  logic push, pop, beat_ok, start_ok, grant_ok, done_now;

  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign pop          = !fifo_empty && host.wr_ready;
  assign beat_ok      = (state_q == GRANT) && (!fifo_full || pop);
  assign push         = core.output_valid && beat_ok;
  // Free space uses the registered occupancy, so a grant only depends on
  // state from before this cycle's push/pop.
  assign free_entries = CW'(FIFO_DEPTH) - fifo_count;
  assign grant_ok     = core.output_request && (free_entries >= CW'(MAX_BURST));
  assign start_ok     = (state_q == IDLE) && fifo_empty && !pending_q;
  assign done_now     = pending_q && fifo_empty && !pop;

  wb_fifo #(
    .WIDTH (LINE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (Clk_32UI),
    .rst_n       (reset_n),
    .push_i      (push),
    .push_data_i (core.output_data),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Grant FSM; output_permit is a register so it rises the cycle after the
  // grant condition and falls the cycle after output_finish.
  always_ff @(posedge Clk_32UI or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      permit_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_ok) begin
            state_q  <= GRANT;
            permit_q <= 1'b1;
          end
        end
        GRANT: begin
          if (core.output_finish) begin
            state_q  <= IDLE;
            permit_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          permit_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    base_d      = base_q;
    line_cnt_d  = line_cnt_q;
    pending_d   = pending_q;
    overflow_d  = overflow_q;
    start_err_d = start_err_q;

    if (start) begin
      if (start_ok) begin
        base_d      = wr_base_addr;
        line_cnt_d  = '0;
        overflow_d  = 1'b0;
        start_err_d = 1'b0;
      end else begin
        start_err_d = 1'b1;
      end
    end

    // start_ok implies an empty FIFO, so it never races with a pop.
    if (pop) line_cnt_d = line_cnt_q + CNT_W'(1);

    if (done_now) pending_d = 1'b0;
    // A finish outside a grant closes nothing, so it is not recorded.
    if ((state_q == GRANT) && core.output_finish) pending_d = 1'b1;

    // A drop in the same cycle as an honoured start is a new error.
    if (core.output_valid && !beat_ok) overflow_d = 1'b1;
  end

  always_ff @(posedge Clk_32UI or negedge reset_n) begin
    if (!reset_n) begin
      base_q      <= '0;
      line_cnt_q  <= '0;
      pending_q   <= 1'b0;
      overflow_q  <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      base_q      <= base_d;
      line_cnt_q  <= line_cnt_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      start_err_q <= start_err_d;
    end
  end

  assign core.output_permit = permit_q;
  assign host.wr_valid      = !fifo_empty;
  assign host.wr_addr       = base_q + ADDR_W'(line_cnt_q);
  assign host.wr_data       = fifo_head;
  assign lines_written      = line_cnt_q;
  assign batch_done         = done_now;
  assign overflow_err       = overflow_q;
  assign start_err          = start_err_q;

endmodule

// File: tb/tb_output_writeback.sv
module tb_output_writeback;
  import output_writeback_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] lines_written;
  logic        batch_done, overflow_err, start_err;

  int tests = 0;
  int fails = 0;

  ow_core_if core_bus ();
  ow_host_if #(.ADDR_W(32)) host_bus ();

  output_writeback #(.FIFO_DEPTH(16), .MAX_BURST(8), .ADDR_W(32)) dut (
    .Clk_32UI      (clk),
    .reset_n       (reset_n),
    .start         (start),
    .wr_base_addr  (base_addr),
    .core          (core_bus.slave),
    .host          (host_bus.master),
    .lines_written (lines_written),
    .batch_done    (batch_done),
    .overflow_err  (overflow_err),
    .start_err     (start_err)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] mk_line(int i);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = {8'(k), 24'(i)};
    return r;
  endfunction

  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (core_bus.output_permit !== 1'b0) begin fails++; $display("FAIL reset_permit: got %0b want 0", core_bus.output_permit); end
    tests++; if (host_bus.wr_valid !== 1'b0) begin fails++; $display("FAIL reset_wr_valid: got %0b want 0", host_bus.wr_valid); end
    tests++; if (lines_written !== 16'd0) begin fails++; $display("FAIL reset_lines: got %0d want 0", lines_written); end
    tests++; if ({batch_done, overflow_err, start_err} !== 3'b000) begin fails++; $display("FAIL reset_status: got %b want 000", {batch_done, overflow_err, start_err}); end
    reset_n = 1'b1;
    @(negedge clk);
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic();
    start = 1'b1; base_addr = 32'h1000; core_bus.output_request = 1'b1; host_bus.wr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++; if (core_bus.output_permit !== 1'b1) begin fails++; $display("FAIL basic_permit: got %0b want 1", core_bus.output_permit); end
    for (int i = 0; i < 3; i++) begin
      core_bus.output_request = 1'b0;
      core_bus.output_valid = 1'b1; core_bus.output_data = mk_line(i); core_bus.output_finish = (i == 2);
      @(negedge clk);
      tests++;
      if (host_bus.wr_valid !== 1'b1 || host_bus.wr_addr !== 32'h1000 + 32'(i) || host_bus.wr_data !== mk_line(i)) begin
        fails++; $display("FAIL basic_write%0d: got v=%0b a=%h want v=1 a=%h", i, host_bus.wr_valid, host_bus.wr_addr, 32'h1000 + 32'(i));
      end
    end
    tests++; if (core_bus.output_permit !== 1'b0) begin fails++; $display("FAIL basic_permit_drop: got %0b want 0", core_bus.output_permit); end
    core_bus.output_valid = 1'b0; core_bus.output_finish = 1'b0;
    @(negedge clk);
    tests++; if (host_bus.wr_valid !== 1'b0 || lines_written !== 16'd3) begin fails++; $display("FAIL basic_drained: got v=%0b lines=%0d want v=0 lines=3", host_bus.wr_valid, lines_written); end
    tests++; if (batch_done !== 1'b1) begin fails++; $display("FAIL basic_batch_done: got %0b want 1", batch_done); end
    @(negedge clk);
    tests++; if (batch_done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse: got %0b want 0", batch_done); end
    $display("[TB] test_basic done, lines_written=%0d", lines_written);
  endtask

  task automatic test_stall();
    start = 1'b1; base_addr = 32'h2000; core_bus.output_request = 1'b1; host_bus.wr_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    tests++; if (core_bus.output_permit !== 1'b1) begin fails++; $display("FAIL stall_permit1: got %0b want 1", core_bus.output_permit); end
    for (int i = 0; i < 8; i++) begin
      core_bus.output_valid = 1'b1; core_bus.output_data = mk_line(10 + i); core_bus.output_finish = (i == 7);
      @(negedge clk);
    end
    core_bus.output_valid = 1'b0; core_bus.output_finish = 1'b0;
    tests++; if (core_bus.output_permit !== 1'b0) begin fails++; $display("FAIL stall_permit_drop: got %0b want 0", core_bus.output_permit); end
    @(negedge clk);
    // exactly MAX_BURST free entries: a second grant is allowed
    tests++; if (core_bus.output_permit !== 1'b1) begin fails++; $display("FAIL stall_permit2_at_8_free: got %0b want 1", core_bus.output_permit); end
    core_bus.output_valid = 1'b1; core_bus.output_data = mk_line(18); core_bus.output_finish = 1'b1;
    @(negedge clk);
    core_bus.output_valid = 1'b0; core_bus.output_finish = 1'b0;
    for (int k = 0; k < 18; k++) begin
      tests++;
      if (core_bus.output_permit !== 1'b0 || host_bus.wr_valid !== 1'b1 || host_bus.wr_data !== mk_line(10) || host_bus.wr_addr !== 32'h2000 || batch_done !== 1'b0) begin
        fails++; $display("FAIL stall_hold%0d: got permit=%0b v=%0b a=%h done=%0b want permit=0 v=1 a=2000 done=0", k, core_bus.output_permit, host_bus.wr_valid, host_bus.wr_addr, batch_done);
      end
      @(negedge clk);
    end
    core_bus.output_request = 1'b0; host_bus.wr_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      tests++;
      if (host_bus.wr_valid !== 1'b1 || host_bus.wr_addr !== 32'h2000 + 32'(j) || host_bus.wr_data !== mk_line(10 + j)) begin
        fails++; $display("FAIL stall_drain%0d: got v=%0b a=%h want v=1 a=%h", j, host_bus.wr_valid, host_bus.wr_addr, 32'h2000 + 32'(j));
      end
      @(negedge clk);
    end
    tests++; if (host_bus.wr_valid !== 1'b0 || lines_written !== 16'd9 || batch_done !== 1'b1 || overflow_err !== 1'b0) begin
      fails++; $display("FAIL stall_end: got v=%0b lines=%0d done=%0b ovf=%0b want 0 9 1 0", host_bus.wr_valid, lines_written, batch_done, overflow_err);
    end
    @(negedge clk);
    $display("[TB] test_stall done, lines_written=%0d", lines_written);
  endtask

  task automatic test_back_to_back();
    int phase = 0, beat = 0, sent = 0, nw = 0, done_cnt = 0;
    start = 1'b1; base_addr = 32'h3000;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 300 && phase != 4; cyc++) begin
      if (batch_done === 1'b1) begin
        done_cnt++;
        if (phase == 1 || phase == 3) phase++;
      end
      host_bus.wr_ready = (cyc % 2 == 1);
      core_bus.output_valid = 1'b0; core_bus.output_finish = 1'b0;
      if (phase == 0 || phase == 2) begin
        core_bus.output_request = 1'b1;
        if (core_bus.output_permit === 1'b1) begin
          core_bus.output_valid = 1'b1; core_bus.output_data = mk_line(100 + sent);
          core_bus.output_finish = (beat == ((phase == 0) ? 4 : 3));
          sent++; beat++;
          if (core_bus.output_finish) begin beat = 0; phase++; core_bus.output_request = 1'b0; end
        end
      end else begin
        core_bus.output_request = 1'b0;
      end
      if (host_bus.wr_valid === 1'b1 && host_bus.wr_ready === 1'b1) begin
        tests++;
        if (host_bus.wr_addr !== 32'h3000 + 32'(nw) || host_bus.wr_data !== mk_line(100 + nw)) begin
          fails++; $display("FAIL b2b_write%0d: got a=%h want a=%h", nw, host_bus.wr_addr, 32'h3000 + 32'(nw));
        end
        nw++;
      end
      @(negedge clk);
    end
    core_bus.output_request = 1'b0; core_bus.output_valid = 1'b0; core_bus.output_finish = 1'b0;
    tests++; if (phase != 4) begin fails++; $display("FAIL b2b_timeout: got phase=%0d want 4", phase); end
    tests++; if (nw != 9 || lines_written !== 16'd9) begin fails++; $display("FAIL b2b_count: got writes=%0d lines=%0d want 9 9", nw, lines_written); end
    tests++; if (done_cnt != 2) begin fails++; $display("FAIL b2b_done_pulses: got %0d want 2", done_cnt); end
    tests++; if (overflow_err !== 1'b0) begin fails++; $display("FAIL b2b_overflow: got %0b want 0", overflow_err); end
    $display("[TB] test_back_to_back done, writes=%0d batches=%0d", nw, done_cnt);
  endtask

  task automatic test_overflow();
    logic [511:0] exp_q [17];
    int nw = 0;
    for (int i = 0; i < 8; i++) begin exp_q[i] = mk_line(200 + i); exp_q[8 + i] = mk_line(300 + i); end
    exp_q[16] = mk_line(309);
    core_bus.output_valid = 1'b1; core_bus.output_data = mk_line(999);
    @(negedge clk);
    core_bus.output_valid = 1'b0;
    tests++; if (overflow_err !== 1'b1 || host_bus.wr_valid !== 1'b0) begin fails++; $display("FAIL ovf_idle_beat: got ovf=%0b v=%0b want 1 0", overflow_err, host_bus.wr_valid); end
    start = 1'b1; base_addr = 32'h4000; host_bus.wr_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    tests++; if (overflow_err !== 1'b0 || start_err !== 1'b0) begin fails++; $display("FAIL ovf_start_clear: got ovf=%0b serr=%0b want 0 0", overflow_err, start_err); end
    for (int g = 0; g < 2; g++) begin
      core_bus.output_request = 1'b1;
      @(negedge clk);
      core_bus.output_request = 1'b0;
      tests++; if (core_bus.output_permit !== 1'b1) begin fails++; $display("FAIL ovf_permit%0d: got %0b want 1", g, core_bus.output_permit); end
      for (int i = 0; i < 8; i++) begin
        core_bus.output_valid = 1'b1; core_bus.output_data = mk_line(200 + 100 * g + i); core_bus.output_finish = (g == 0 && i == 7);
        @(negedge clk);
      end
      core_bus.output_valid = 1'b0; core_bus.output_finish = 1'b0;
    end
    tests++; if (overflow_err !== 1'b0) begin fails++; $display("FAIL ovf_fill_to_full: got %0b want 0", overflow_err); end
    core_bus.output_valid = 1'b1; core_bus.output_data = mk_line(308);
    @(negedge clk);
    tests++; if (overflow_err !== 1'b1) begin fails++; $display("FAIL ovf_full_drop: got %0b want 1", overflow_err); end
    core_bus.output_data = mk_line(309); core_bus.output_finish = 1'b1; host_bus.wr_ready = 1'b1;
    for (int c = 0; c < 40 && host_bus.wr_valid === 1'b1; c++) begin
      tests++;
      if (nw > 16 || host_bus.wr_addr !== 32'h4000 + 32'(nw) || host_bus.wr_data !== exp_q[nw % 17]) begin
        fails++; $display("FAIL ovf_drain%0d: got a=%h want a=%h", nw, host_bus.wr_addr, 32'h4000 + 32'(nw));
      end
      nw++;
      @(negedge clk);
      core_bus.output_valid = 1'b0; core_bus.output_finish = 1'b0;
    end
    tests++; if (nw != 17 || lines_written !== 16'd17 || batch_done !== 1'b1) begin
      fails++; $display("FAIL ovf_drain_end: got writes=%0d lines=%0d done=%0b want 17 17 1", nw, lines_written, batch_done);
    end
    @(negedge clk);
    start = 1'b1; base_addr = 32'h4800;
    @(negedge clk);
    start = 1'b0;
    tests++; if (overflow_err !== 1'b0) begin fails++; $display("FAIL ovf_cleared_by_start: got %0b want 0", overflow_err); end
    $display("[TB] test_overflow done, writes=%0d", nw);
  endtask

  task automatic test_start_err();
    start = 1'b1; base_addr = 32'h5000; core_bus.output_request = 1'b1; host_bus.wr_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; core_bus.output_request = 1'b0;
    for (int i = 0; i < 2; i++) begin
      core_bus.output_valid = 1'b1; core_bus.output_data = mk_line(400 + i); core_bus.output_finish = (i == 1);
      @(negedge clk);
    end
    core_bus.output_valid = 1'b0; core_bus.output_finish = 1'b0;
    start = 1'b1; base_addr = 32'h9999;
    @(negedge clk);
    start = 1'b0;
    tests++; if (start_err !== 1'b1) begin fails++; $display("FAIL serr_set: got %0b want 1", start_err); end
    tests++; if (host_bus.wr_addr !== 32'h5000 || host_bus.wr_data !== mk_line(400)) begin fails++; $display("FAIL serr_base_kept: got a=%h want a=5000", host_bus.wr_addr); end
    host_bus.wr_ready = 1'b1;
    @(negedge clk);
    tests++; if (host_bus.wr_addr !== 32'h5001 || host_bus.wr_data !== mk_line(401)) begin fails++; $display("FAIL serr_second_line: got a=%h want a=5001", host_bus.wr_addr); end
    @(negedge clk);
    tests++; if (batch_done !== 1'b1 || lines_written !== 16'd2) begin fails++; $display("FAIL serr_done: got done=%0b lines=%0d want 1 2", batch_done, lines_written); end
    @(negedge clk);
    start = 1'b1; base_addr = 32'h6000;
    @(negedge clk);
    start = 1'b0;
    tests++; if (start_err !== 1'b0 || host_bus.wr_addr !== 32'h6000 || lines_written !== 16'd0) begin
      fails++; $display("FAIL serr_restart: got serr=%0b a=%h lines=%0d want 0 6000 0", start_err, host_bus.wr_addr, lines_written);
    end
    $display("[TB] test_start_err done");
  endtask

  task automatic test_zero_beat();
    core_bus.output_request = 1'b1;
    @(negedge clk);
    core_bus.output_request = 1'b0;
    tests++; if (core_bus.output_permit !== 1'b1) begin fails++; $display("FAIL zero_permit: got %0b want 1", core_bus.output_permit); end
    core_bus.output_finish = 1'b1;
    @(negedge clk);
    core_bus.output_finish = 1'b0;
    tests++; if (core_bus.output_permit !== 1'b0 || batch_done !== 1'b1) begin fails++; $display("FAIL zero_done: got permit=%0b done=%0b want 0 1", core_bus.output_permit, batch_done); end
    @(negedge clk);
    tests++; if (batch_done !== 1'b0) begin fails++; $display("FAIL zero_done_pulse: got %0b want 0", batch_done); end
    $display("[TB] test_zero_beat done");
  endtask

  task automatic test_async_reset();
    start = 1'b1; base_addr = 32'h7000; core_bus.output_request = 1'b1; host_bus.wr_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; core_bus.output_request = 1'b0;
    for (int i = 0; i < 2; i++) begin
      core_bus.output_valid = 1'b1; core_bus.output_data = mk_line(500 + i);
      @(negedge clk);
    end
    core_bus.output_valid = 1'b0;
    tests++; if (core_bus.output_permit !== 1'b1 || host_bus.wr_valid !== 1'b1) begin fails++; $display("FAIL arst_pre: got permit=%0b v=%0b want 1 1", core_bus.output_permit, host_bus.wr_valid); end
    #2 reset_n = 1'b0;
    #1;
    tests++; if (core_bus.output_permit !== 1'b0 || host_bus.wr_valid !== 1'b0) begin fails++; $display("FAIL arst_immediate: got permit=%0b v=%0b want 0 0", core_bus.output_permit, host_bus.wr_valid); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if (batch_done !== 1'b0 || host_bus.wr_valid !== 1'b0 || lines_written !== 16'd0 || core_bus.output_permit !== 1'b0) begin
        fails++; $display("FAIL arst_after%0d: got done=%0b v=%0b lines=%0d permit=%0b want all 0", k, batch_done, host_bus.wr_valid, lines_written, core_bus.output_permit);
      end
    end
    $display("[TB] test_async_reset done");
  endtask

  initial begin
    core_bus.output_request = 1'b0;
    core_bus.output_valid   = 1'b0;
    core_bus.output_finish  = 1'b0;
    core_bus.output_data    = '0;
    host_bus.wr_ready       = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_start_err();
    test_zero_beat();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/output_writeback.md
Name: output_writeback

Overview:
- Downstream consumer of the SMEM core's result stream (output_request / output_permit / output_data / output_valid / output_finish).
- Grants the core permission to emit a burst of 512-bit result lines and buffers them in a FIFO.
- Drains the FIFO to the host write port at sequential cache-line addresses.
- Reports per-batch completion and error status to the host-side controller.

Parameters:
- FIFO_DEPTH, 16, buffer entries (power of 2, >= MAX_BURST).
- MAX_BURST, 8, maximum lines the core may send per grant; permit issued only with this many free entries.
- ADDR_W, 32, host line-address width.

Ports:
- Clk_32UI  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin new batch, latch wr_base_addr, clear line count and errors
- wr_base_addr  in  ADDR_W  base line address of result region
- output_request  in  1  core has results ready
- output_permit  out  1  grant; held high until output_finish
- output_data  in  512  result line
- output_valid  in  1  output_data valid this cycle
- output_finish  in  1  single-cycle pulse closing a grant; may coincide with the last beat
- wr_valid  out  1  host write request
- wr_addr  out  ADDR_W  line address of wr_data
- wr_data  out  512  line to write
- wr_ready  in  1  host accepts the write when wr_valid && wr_ready
- lines_written  out  16  lines accepted by host since start
- batch_done  out  1  one-cycle pulse: a grant has finished and all its lines have been written
- overflow_err  out  1  sticky: beat dropped (FIFO full or beat outside GRANT)
- start_err  out  1  sticky: start ignored because the block was busy

Behaviour:
- Reset: all outputs 0; FSM in IDLE; FIFO empty; base = 0; line_cnt = 0; pending_done = 0.
- FSM, two states:
  - IDLE -> GRANT when output_request && free_entries >= MAX_BURST. output_permit is registered and rises the cycle after the condition holds.
  - GRANT: output_permit = 1. output_finish -> IDLE; output_permit drops the next cycle.
  - output_request deasserting while in GRANT does not revoke the grant; only output_finish ends it.
- Push:
  - output_valid && GRANT && FIFO not full -> push output_data.
  - A beat in the same cycle as output_finish is accepted.
  - output_valid in IDLE, or when full with no pop in that cycle -> beat dropped, overflow_err set.
  - Push when full with a simultaneous pop is accepted.
- Drain:
  - wr_valid = FIFO not empty; wr_data = FIFO head; wr_addr = base + line_cnt (modulo 2^ADDR_W).
  - Minimum latency: beat accepted in cycle N is presented on wr_valid in cycle N+1.
  - wr_valid/wr_addr/wr_data are held stable until wr_ready.
  - On handshake: pop, line_cnt++ (wraps at 2^16), lines_written = line_cnt.
- Completion:
  - output_finish sets pending_done.
  - When pending_done && FIFO empty && no handshake in that cycle: batch_done pulses one cycle and pending_done clears.
  - A finish with zero beats still produces batch_done one cycle after finish.
- start:
  - Honoured only in IDLE with FIFO empty and pending_done = 0. Effect: base <= wr_base_addr, line_cnt <= 0, both error flags cleared.
  - Otherwise start is ignored and start_err is set.
  - A simultaneous start and output_request in IDLE: start applies this cycle; the grant is evaluated in the same cycle.
- Free-entry count = FIFO_DEPTH - occupancy, computed from registered occupancy before the current cycle's push/pop.
- Asynchronous reset mid-burst: FIFO contents are discarded, permit drops immediately, and no batch_done is issued.

Decomposition:
- Shared package holds LINE_W = 512, ADDR_W default, and FSM state enum {IDLE, GRANT}.
- One natural sub-module, wb_fifo:
  - synchronous FIFO, width LINE_W, depth FIFO_DEPTH;
  - ports push/pop/full/empty/count plus head data;
  - async active-low reset on pointers only.
- Top level contains the FSM, address counter, completion and error logic.

Test Plan:
- Reset, start with wr_base_addr=0x1000, request, 3 beats, finish on 3rd beat, wr_ready=1 -> permit 1 cycle after request; writes to 0x1000..0x1002; lines_written=3; batch_done one cycle after last write.
- 8-beat burst with wr_ready=0 for 20 cycles -> FIFO holds 8 and no second permit while free < 8; on release, 8 writes in order with wr_data unchanged while stalled.
- Two consecutive grants (5 beats, then 4 beats), wr_ready toggling every cycle -> 9 writes at base..base+8; two batch_done pulses; no overflow.
- output_valid pulsed in IDLE, then a 9th beat within one grant on a full FIFO -> beats dropped; overflow_err=1; subsequent start clears it.
- start asserted while FIFO non-empty -> ignored; start_err=1; base unchanged.
- reset_n asserted during GRANT after 2 beats -> permit and wr_valid are 0 immediately; after release, lines_written=0 and no batch_done.
